rf_wb_scheduler: RTL and testbench
==================================

# rf_wb_scheduler

Write-port scheduler and scoreboard for the 32×32 integer register file. It shares the register file's single write port between the in-order pipeline writeback (WB) and an out-of-order long-latency completion port (LL: load-miss/divider), using a bounded-starvation priority rule. It also tracks registers with outstanding LL writes and raises the decode (ID) stall for RAW/WAW hazards. It sits between the WB stage, the LL unit and the register file write port.

## Interface
- `LL_STARVE_MAX`, default 4: maximum consecutive cycles a valid LL completion may be refused before WB is forced to stall; legal range 1..15.
- `REGIDX_WIDTH`, default 5: register index width, from the shared package.

Ports:
- `i_clk` in 1: clock.
- `i_rst_n` in 1: reset, synchronous, active-low. Clock is `i_clk`.
- `i_wb_valid`, `i_wb_rd`, `i_wb_data` in 1/5/32: pipeline writeback request.
- `o_wb_stall` out 1: WB not granted this cycle; the pipeline holds its WB stage.
- `i_ll_issue`, `i_ll_issue_rd` in 1/5: a long-latency op with destination rd is issued this cycle.
- `i_ll_valid`, `i_ll_rd`, `i_ll_data` in 1/5/32: LL completion request.
- `o_ll_ready` out 1: LL completion accepted; transfer occurs when `i_ll_valid & o_ll_ready`.
- `i_id_rs1`, `i_id_rs2`, `i_id_rd` in 5 each: decode operand and destination indices.
- `i_id_use_rs1`, `i_id_use_rs2`, `i_id_use_rd` in 1 each: qualifiers for the decode indices.
- `o_id_stall` out 1: decode hazard on a pending register.
- `o_rd_wen`, `o_rd_addr`, `o_rd_data` out 1/5/32: drive the register file write port.
- `o_pending_cnt` out 6: number of registers with an outstanding LL write.

## Operation
**State**
- `pending[31:1]`: one bit per register; x0 is never pending.
- `starve_cnt`: 4-bit counter.
- `pending_cnt`: 6-bit counter.

**Arbitration** (combinational on current inputs and state)
- `force_ll = i_ll_valid & (starve_cnt >= LL_STARVE_MAX)`.
- LL is granted when `i_ll_valid & (force_ll | ~i_wb_valid)`.
- Otherwise WB is granted when `i_wb_valid`.
- `o_wb_stall = i_wb_valid & LL granted`.
- `o_ll_ready = LL granted`.

**Write port**
- `o_rd_addr` and `o_rd_data` come from the granted source.
- `o_rd_wen = granted & (rd != 0)`.
- An LL completion with rd=0 is still accepted and consumed, but produces no write.

**starve_cnt**
- Increments (saturating at 15) when `i_ll_valid & ~o_ll_ready`.
- Clears to 0 on an LL handshake or when `~i_ll_valid`.

**Scoreboard**
- Set: `i_ll_issue & i_ll_issue_rd != 0` sets `pending[issue_rd]`.
- Clear: an LL handshake clears `pending[i_ll_rd]`.
- Same index set and cleared in the same cycle: set wins and the bit stays 1.
- `pending_cnt` tracks popcount(pending) incrementally: +1 on a set of a 0 bit, −1 on a clear that is not overridden.
- The issuer never issues to an already-pending rd; this is guaranteed by the WAW stall. If it happens anyway, the bit stays 1 and the count is unchanged.

**Hazard**
- A register counts as hazardous when `pending[r] & ~(LL handshake this cycle & i_ll_rd == r)`. Same-cycle completion is resolved by the register file's write-to-read bypass.
- `o_id_stall` is the OR of:
  - `use_rs1 & hazard(rs1)`
  - `use_rs2 & hazard(rs2)`
  - `use_rd & hazard(rd)`
- Index 0 never causes a stall.

## Timing
- Arbitration, write port, stalls and ready have zero latency (combinational). The register file commits at the next `posedge i_clk`.
- Scoreboard and counters update at `posedge i_clk`. An issue at cycle N stalls a dependent decode from cycle N+1.
- Reset (`i_rst_n`=0 at posedge):
  - pending = 0, starve_cnt = 0, pending_cnt = 0.
  - While `i_rst_n` is low: `o_rd_wen`, `o_ll_ready`, `o_wb_stall` and `o_id_stall` are forced to 0, and `o_pending_cnt` = 0.
- Reset mid-operation drops all pending state. The LL unit is reset by the same signal.
- A held WB request must keep its `rd`/`data` stable while stalled.
- An LL request holds `valid`/`rd`/`data` until the handshake.

## Structure
- Shared package `rv32i_pkg`: `REGIDX_WIDTH`, `NUM_REGS`=32, and a typedef `wb_req_t {valid, rd, data}` reused by the WB and LL ports.
- One natural sub-module, `rf_scoreboard`: pending bits, `pending_cnt` and the hazard lookup.
- The arbiter and starvation counter stay in the top module.

## Test plan
- **WB only:** wb_valid=1, rd=5, data=0xDEADBEEF → `o_rd_wen`=1, addr=5, `o_wb_stall`=0. The register file reads back 0xDEADBEEF.
- **LL starvation:** LL_STARVE_MAX=4, wb_valid and ll_valid (rd=7) held high → ready=0 for 4 cycles. Cycle 5: ready=1, `o_wb_stall`=1, write addr=7. Counter returns to 0.
- **RAW:** issue rd=10. Next cycle ID rs1=10, use_rs1=1 → `o_id_stall`=1, `o_pending_cnt`=1. On the cycle the LL rd=10 handshake occurs, stall=0; next cycle `o_pending_cnt`=0.
- **Same-cycle set/clear:** issue rd=3 in the same cycle as the LL completion for rd=3 → pending[3] stays 1 and the count is unchanged.
- **x0:** issue rd=0 → no pending, count 0. LL completion rd=0 → ready=1, `o_rd_wen`=0. WB rd=0 → `o_rd_wen`=0.
- **Reset:** 3 registers pending, assert `i_rst_n`=0 for one cycle → `o_pending_cnt`=0 and all stalls/ready deasserted. A dependent decode does not stall afterwards.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I integer-core definitions: register-file geometry and the
// writeback request record used by both register-file write sources.
package rv32i_pkg;

    localparam int REGIDX_WIDTH = 5;
    localparam int NUM_REGS     = 32;
    localparam int XLEN         = 32;
    localparam int PCNT_WIDTH   = 6;

    typedef struct packed {
        logic                    valid;
        logic [REGIDX_WIDTH-1:0] rd;
        logic [XLEN-1:0]         data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_scheduler_if.sv
// Bundle of every signal between the write-port scheduler and its neighbours
// (WB stage, LL unit, decode, register file write port).
interface rf_wb_scheduler_if;
    import rv32i_pkg::*;

    logic                    i_wb_valid;
    logic [REGIDX_WIDTH-1:0] i_wb_rd;
    logic [XLEN-1:0]         i_wb_data;
    logic                    o_wb_stall;

    logic                    i_ll_issue;
    logic [REGIDX_WIDTH-1:0] i_ll_issue_rd;
    logic                    i_ll_valid;
    logic [REGIDX_WIDTH-1:0] i_ll_rd;
    logic [XLEN-1:0]         i_ll_data;
    logic                    o_ll_ready;

    logic [REGIDX_WIDTH-1:0] i_id_rs1;
    logic [REGIDX_WIDTH-1:0] i_id_rs2;
    logic [REGIDX_WIDTH-1:0] i_id_rd;
    logic                    i_id_use_rs1;
    logic                    i_id_use_rs2;
    logic                    i_id_use_rd;
    logic                    o_id_stall;

    logic                    o_rd_wen;
    logic [REGIDX_WIDTH-1:0] o_rd_addr;
    logic [XLEN-1:0]         o_rd_data;
    logic [PCNT_WIDTH-1:0]   o_pending_cnt;

    modport slave (
        input  i_wb_valid, i_wb_rd, i_wb_data,
        output o_wb_stall,
        input  i_ll_issue, i_ll_issue_rd,
        input  i_ll_valid, i_ll_rd, i_ll_data,
        output o_ll_ready,
        input  i_id_rs1, i_id_rs2, i_id_rd,
        input  i_id_use_rs1, i_id_use_rs2, i_id_use_rd,
        output o_id_stall,
        output o_rd_wen, o_rd_addr, o_rd_data,
        output o_pending_cnt
    );

    modport master (
        output i_wb_valid, i_wb_rd, i_wb_data,
        input  o_wb_stall,
        output i_ll_issue, i_ll_issue_rd,
        output i_ll_valid, i_ll_rd, i_ll_data,
        input  o_ll_ready,
        output i_id_rs1, i_id_rs2, i_id_rd,
        output i_id_use_rs1, i_id_use_rs2, i_id_use_rd,
        input  o_id_stall,
        input  o_rd_wen, o_rd_addr, o_rd_data,
        input  o_pending_cnt
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for registers awaiting a long-latency result:
// one bit per register, an incremental population count and the decode hazard lookup.
module rf_scoreboard
    import rv32i_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_set_en,
    input  logic [REGIDX_WIDTH-1:0] i_set_idx,
    input  logic                    i_clr_en,
    input  logic [REGIDX_WIDTH-1:0] i_clr_idx,
    input  logic [REGIDX_WIDTH-1:0] i_rs1,
    input  logic [REGIDX_WIDTH-1:0] i_rs2,
    input  logic [REGIDX_WIDTH-1:0] i_rd,
    input  logic                    i_use_rs1,
    input  logic                    i_use_rs2,
    input  logic                    i_use_rd,
    output logic                    o_hazard,
    output logic [PCNT_WIDTH-1:0]   o_pending_cnt
);

    logic [NUM_REGS-1:0]   r_pending;
    logic [NUM_REGS-1:0]   w_set_vec;
    logic [NUM_REGS-1:0]   w_clr_vec;
    logic [NUM_REGS-1:0]   w_hazard_vec;
    logic [NUM_REGS-1:0]   w_pending_next;
    logic [PCNT_WIDTH-1:0] r_pending_cnt;
    logic                  w_inc;
    logic                  w_dec;

    // Bit 0 never decodes, so x0 can never become pending.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_decode
            if (gi == 0) begin : g_x0
                assign w_set_vec[gi] = 1'b0;
                assign w_clr_vec[gi] = 1'b0;
            end else begin : g_reg
                assign w_set_vec[gi] = i_set_en & (i_set_idx == REGIDX_WIDTH'(gi));
                assign w_clr_vec[gi] = i_clr_en & (i_clr_idx == REGIDX_WIDTH'(gi));
            end
        end
    endgenerate

    // A set on the same index as a clear wins, keeping the bit pending.
    assign w_pending_next = (r_pending | w_set_vec) & ~(w_clr_vec & ~w_set_vec);
    assign w_inc = |(w_set_vec & ~r_pending);
    assign w_dec = |(w_clr_vec & ~w_set_vec & r_pending);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pending     <= '0;
            r_pending_cnt <= '0;
        end else begin
            r_pending     <= w_pending_next;
            r_pending_cnt <= r_pending_cnt + PCNT_WIDTH'(w_inc) - PCNT_WIDTH'(w_dec);
        end
    end

    // A completion landing this cycle is bypassed by the register file.
    assign w_hazard_vec = r_pending & ~w_clr_vec;

    assign o_hazard = (i_use_rs1 & w_hazard_vec[i_rs1])
                    | (i_use_rs2 & w_hazard_vec[i_rs2])
                    | (i_use_rd  & w_hazard_vec[i_rd]);

    assign o_pending_cnt = r_pending_cnt;

endmodule

// File: rtl/rf_wb_scheduler.sv
// Shares the register file write port between in-order writeback and long-latency
// completions, with a bounded-starvation rule for LL, and raises decode hazard stalls.
module rf_wb_scheduler
    import rv32i_pkg::*;
#(
    parameter int LL_STARVE_MAX = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    rf_wb_scheduler_if.slave   bus
);

    wb_req_t                 w_wb_req;
    wb_req_t                 w_ll_req;
    wb_req_t                 w_sel_req;
    logic [3:0]              r_starve_cnt;
    logic                    w_force_ll;
    logic                    w_ll_grant;
    logic                    w_wb_grant;
    logic                    w_sb_hazard;
    logic [PCNT_WIDTH-1:0]   w_sb_pending_cnt;

    assign w_wb_req = '{valid: bus.i_wb_valid, rd: bus.i_wb_rd, data: bus.i_wb_data};
    assign w_ll_req = '{valid: bus.i_ll_valid, rd: bus.i_ll_rd, data: bus.i_ll_data};

    // WB normally wins; LL takes the port once it has been refused LL_STARVE_MAX times.
    assign w_force_ll = w_ll_req.valid & (r_starve_cnt >= 4'(LL_STARVE_MAX));
    assign w_ll_grant = i_rst_n & w_ll_req.valid & (w_force_ll | ~w_wb_req.valid);
    assign w_wb_grant = i_rst_n & w_wb_req.valid & ~w_ll_grant;

    assign w_sel_req = w_ll_grant ? w_ll_req : w_wb_req;

    assign bus.o_ll_ready = w_ll_grant;
    assign bus.o_wb_stall = i_rst_n & w_wb_req.valid & w_ll_grant;
    assign bus.o_rd_wen   = (w_ll_grant | w_wb_grant) & w_sel_req.valid
                          & (w_sel_req.rd != '0);
    assign bus.o_rd_addr  = w_sel_req.rd;
    assign bus.o_rd_data  = w_sel_req.data;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_ll_req.valid && !w_ll_grant) begin
            if (r_starve_cnt != 4'hF) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end

    rf_scoreboard u_scoreboard (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_set_en      (bus.i_ll_issue),
        .i_set_idx     (bus.i_ll_issue_rd),
        .i_clr_en      (w_ll_grant),
        .i_clr_idx     (w_ll_req.rd),
        .i_rs1         (bus.i_id_rs1),
        .i_rs2         (bus.i_id_rs2),
        .i_rd          (bus.i_id_rd),
        .i_use_rs1     (bus.i_id_use_rs1),
        .i_use_rs2     (bus.i_id_use_rs2),
        .i_use_rd      (bus.i_id_use_rd),
        .o_hazard      (w_sb_hazard),
        .o_pending_cnt (w_sb_pending_cnt)
    );

    assign bus.o_id_stall    = i_rst_n & w_sb_hazard;
    assign bus.o_pending_cnt = i_rst_n ? w_sb_pending_cnt : '0;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler: per-feature tasks with inline checks plus a
// write-port scoreboard fed with expected register-file writes as stimulus is driven.
module tb_rf_wb_scheduler;
    import rv32i_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_wb_scheduler_if bus ();

    rf_wb_scheduler #(.LL_STARVE_MAX(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] rf_model [32];
    wr_t         mon_exp;

    // Register file model: commits the write port at the clock edge.
    always @(posedge clk) begin
        if (rst_n && bus.o_rd_wen) rf_model[bus.o_rd_addr] <= bus.o_rd_data;
    end

    // Write-port monitor: every write must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n && bus.o_rd_wen) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected got addr=%0d data=%h exp none", bus.o_rd_addr, bus.o_rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.o_rd_addr !== mon_exp.addr || bus.o_rd_data !== mon_exp.data) begin
                    errors++;
                    $display("FAIL wr_match got addr=%0d data=%h exp addr=%0d data=%h",
                             bus.o_rd_addr, bus.o_rd_data, mon_exp.addr, mon_exp.data);
                end else begin
                    $display("WR addr=%0d data=%h ok", bus.o_rd_addr, bus.o_rd_data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic idle();
        bus.i_wb_valid    = 1'b0; bus.i_wb_rd = '0; bus.i_wb_data = '0;
        bus.i_ll_issue    = 1'b0; bus.i_ll_issue_rd = '0;
        bus.i_ll_valid    = 1'b0; bus.i_ll_rd = '0; bus.i_ll_data = '0;
        bus.i_id_rs1      = '0;   bus.i_id_rs2 = '0; bus.i_id_rd = '0;
        bus.i_id_use_rs1  = 1'b0; bus.i_id_use_rs2 = 1'b0; bus.i_id_use_rd = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_wb_valid = 1'b1; bus.i_wb_rd = 5'd4; bus.i_wb_data = 32'h1111_2222;
        bus.i_ll_valid = 1'b1; bus.i_ll_rd = 5'd9; bus.i_ll_data = 32'h3333_4444;
        bus.i_ll_issue = 1'b1; bus.i_ll_issue_rd = 5'd6;
        bus.i_id_rs1 = 5'd6; bus.i_id_use_rs1 = 1'b1;
        adv();
        mid();
        checks++; if (bus.o_rd_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got=%b exp=0", bus.o_rd_wen); end
        checks++; if (bus.o_ll_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.o_ll_ready); end
        checks++; if (bus.o_wb_stall !== 1'b0) begin errors++; $display("FAIL reset_wb_stall got=%b exp=0", bus.o_wb_stall); end
        checks++; if (bus.o_id_stall !== 1'b0) begin errors++; $display("FAIL reset_id_stall got=%b exp=0", bus.o_id_stall); end
        checks++; if (bus.o_pending_cnt !== 6'd0) begin errors++; $display("FAIL reset_pcnt got=%0d exp=0", bus.o_pending_cnt); end
        adv();
        idle();
        rst_n = 1'b1;
        bus.i_id_rs1 = 5'd6; bus.i_id_use_rs1 = 1'b1;
        mid();
        checks++; if (bus.o_pending_cnt !== 6'd0) begin errors++; $display("FAIL reset_issue_ignored got=%0d exp=0", bus.o_pending_cnt); end
        checks++; if (bus.o_id_stall !== 1'b0) begin errors++; $display("FAIL reset_no_hazard got=%b exp=0", bus.o_id_stall); end
        adv();
        idle();
    endtask

    task automatic test_wb_only();
        bus.i_wb_valid = 1'b1; bus.i_wb_rd = 5'd5; bus.i_wb_data = 32'hDEAD_BEEF;
        push_wr(5'd5, 32'hDEAD_BEEF);
        mid();
        checks++; if (bus.o_rd_wen !== 1'b1) begin errors++; $display("FAIL wb_wen got=%b exp=1", bus.o_rd_wen); end
        checks++; if (bus.o_rd_addr !== 5'd5) begin errors++; $display("FAIL wb_addr got=%0d exp=5", bus.o_rd_addr); end
        checks++; if (bus.o_wb_stall !== 1'b0) begin errors++; $display("FAIL wb_stall got=%b exp=0", bus.o_wb_stall); end
        adv();
        idle();
        mid();
        checks++; if (rf_model[5] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wb_readback got=%h exp=deadbeef", rf_model[5]); end
        adv();
    endtask

    task automatic test_ll_starvation();
        bus.i_wb_valid = 1'b1; bus.i_wb_rd = 5'd1; bus.i_wb_data = 32'hAAAA_0001;
        bus.i_ll_valid = 1'b1; bus.i_ll_rd = 5'd7; bus.i_ll_data = 32'hBBBB_0007;
        for (int i = 0; i < 4; i++) begin
            push_wr(5'd1, 32'hAAAA_0001);
            mid();
            checks++; if (bus.o_ll_ready !== 1'b0) begin errors++; $display("FAIL starve_ready_c%0d got=%b exp=0", i, bus.o_ll_ready); end
            checks++; if (bus.o_wb_stall !== 1'b0) begin errors++; $display("FAIL starve_wb_stall_c%0d got=%b exp=0", i, bus.o_wb_stall); end
            adv();
        end
        push_wr(5'd7, 32'hBBBB_0007);
        mid();
        checks++; if (bus.o_ll_ready !== 1'b1) begin errors++; $display("FAIL starve_forced_ready got=%b exp=1", bus.o_ll_ready); end
        checks++; if (bus.o_wb_stall !== 1'b1) begin errors++; $display("FAIL starve_forced_wb_stall got=%b exp=1", bus.o_wb_stall); end
        checks++; if (bus.o_rd_addr !== 5'd7) begin errors++; $display("FAIL starve_forced_addr got=%0d exp=7", bus.o_rd_addr); end
        adv();
        bus.i_ll_valid = 1'b0;
        push_wr(5'd1, 32'hAAAA_0001);
        mid();
        checks++; if (bus.o_wb_stall !== 1'b0) begin errors++; $display("FAIL starve_wb_resume got=%b exp=0", bus.o_wb_stall); end
        adv();
        bus.i_ll_valid = 1'b1; bus.i_ll_rd = 5'd8; bus.i_ll_data = 32'hCCCC_0008;
        push_wr(5'd1, 32'hAAAA_0001);
        mid();
        checks++; if (bus.o_ll_ready !== 1'b0) begin errors++; $display("FAIL starve_cnt_cleared got=%b exp=0", bus.o_ll_ready); end
        adv();
        bus.i_wb_valid = 1'b0;
        push_wr(5'd8, 32'hCCCC_0008);
        mid();
        checks++; if (bus.o_ll_ready !== 1'b1) begin errors++; $display("FAIL ll_idle_wb_ready got=%b exp=1", bus.o_ll_ready); end
        adv();
        idle();
    endtask

    task automatic test_raw();
        bus.i_ll_issue = 1'b1; bus.i_ll_issue_rd = 5'd10;
        adv();
        bus.i_ll_issue = 1'b0;
        bus.i_id_rs1 = 5'd10; bus.i_id_use_rs1 = 1'b1;
        mid();
        checks++; if (bus.o_id_stall !== 1'b1) begin errors++; $display("FAIL raw_rs1_stall got=%b exp=1", bus.o_id_stall); end
        checks++; if (bus.o_pending_cnt !== 6'd1) begin errors++; $display("FAIL raw_pcnt got=%0d exp=1", bus.o_pending_cnt); end
        bus.i_id_use_rs1 = 1'b0; bus.i_id_rs2 = 5'd10; bus.i_id_use_rs2 = 1'b1;
        #1;
        checks++; if (bus.o_id_stall !== 1'b1) begin errors++; $display("FAIL raw_rs2_stall got=%b exp=1", bus.o_id_stall); end
        bus.i_id_rs2 = 5'd11;
        #1;
        checks++; if (bus.o_id_stall !== 1'b0) begin errors++; $display("FAIL raw_rs2_other got=%b exp=0", bus.o_id_stall); end
        bus.i_id_use_rs2 = 1'b0; bus.i_id_rd = 5'd10; bus.i_id_use_rd = 1'b1;
        #1;
        checks++; if (bus.o_id_stall !== 1'b1) begin errors++; $display("FAIL waw_rd_stall got=%b exp=1", bus.o_id_stall); end
        adv();
        bus.i_id_use_rd = 1'b0; bus.i_id_use_rs1 = 1'b1;
        bus.i_ll_valid = 1'b1; bus.i_ll_rd = 5'd10; bus.i_ll_data = 32'h0000_A5A5;
        push_wr(5'd10, 32'h0000_A5A5);
        mid();
        checks++; if (bus.o_ll_ready !== 1'b1) begin errors++; $display("FAIL raw_ll_ready got=%b exp=1", bus.o_ll_ready); end
        checks++; if (bus.o_id_stall !== 1'b0) begin errors++; $display("FAIL raw_bypass_stall got=%b exp=0", bus.o_id_stall); end
        checks++; if (bus.o_pending_cnt !== 6'd1) begin errors++; $display("FAIL raw_pcnt_hs got=%0d exp=1", bus.o_pending_cnt); end
        adv();
        bus.i_ll_valid = 1'b0;
        mid();
        checks++; if (bus.o_pending_cnt !== 6'd0) begin errors++; $display("FAIL raw_pcnt_after got=%0d exp=0", bus.o_pending_cnt); end
        checks++; if (bus.o_id_stall !== 1'b0) begin errors++; $display("FAIL raw_stall_after got=%b exp=0", bus.o_id_stall); end
        adv();
        idle();
    endtask

    task automatic test_same_cycle();
        bus.i_ll_issue = 1'b1; bus.i_ll_issue_rd = 5'd3;
        adv();
        bus.i_ll_valid = 1'b1; bus.i_ll_rd = 5'd3; bus.i_ll_data = 32'h0303_0303;
        push_wr(5'd3, 32'h0303_0303);
        mid();
        checks++; if (bus.o_ll_ready !== 1'b1) begin errors++; $display("FAIL same_ready got=%b exp=1", bus.o_ll_ready); end
        adv();
        bus.i_ll_issue = 1'b0; bus.i_ll_valid = 1'b0;
        bus.i_id_rs1 = 5'd3; bus.i_id_use_rs1 = 1'b1;
        mid();
        checks++; if (bus.o_pending_cnt !== 6'd1) begin errors++; $display("FAIL same_pcnt got=%0d exp=1", bus.o_pending_cnt); end
        checks++; if (bus.o_id_stall !== 1'b1) begin errors++; $display("FAIL same_still_pending got=%b exp=1", bus.o_id_stall); end
        adv();
        bus.i_ll_valid = 1'b1; bus.i_ll_data = 32'h0303_FFFF;
        push_wr(5'd3, 32'h0303_FFFF);
        adv();
        bus.i_ll_valid = 1'b0;
        mid();
        checks++; if (bus.o_pending_cnt !== 6'd0) begin errors++; $display("FAIL same_drained got=%0d exp=0", bus.o_pending_cnt); end
        adv();
        idle();
    endtask

    task automatic test_x0();
        bus.i_ll_issue = 1'b1; bus.i_ll_issue_rd = 5'd0;
        adv();
        bus.i_ll_issue = 1'b0;
        bus.i_id_rs1 = 5'd0; bus.i_id_use_rs1 = 1'b1;
        mid();
        checks++; if (bus.o_pending_cnt !== 6'd0) begin errors++; $display("FAIL x0_pcnt got=%0d exp=0", bus.o_pending_cnt); end
        checks++; if (bus.o_id_stall !== 1'b0) begin errors++; $display("FAIL x0_stall got=%b exp=0", bus.o_id_stall); end
        adv();
        bus.i_ll_valid = 1'b1; bus.i_ll_rd = 5'd0; bus.i_ll_data = 32'hFFFF_0000;
        mid();
        checks++; if (bus.o_ll_ready !== 1'b1) begin errors++; $display("FAIL x0_ll_ready got=%b exp=1", bus.o_ll_ready); end
        checks++; if (bus.o_rd_wen !== 1'b0) begin errors++; $display("FAIL x0_ll_wen got=%b exp=0", bus.o_rd_wen); end
        adv();
        bus.i_ll_valid = 1'b0;
        bus.i_wb_valid = 1'b1; bus.i_wb_rd = 5'd0; bus.i_wb_data = 32'h0000_FFFF;
        mid();
        checks++; if (bus.o_rd_wen !== 1'b0) begin errors++; $display("FAIL x0_wb_wen got=%b exp=0", bus.o_rd_wen); end
        checks++; if (bus.o_wb_stall !== 1'b0) begin errors++; $display("FAIL x0_wb_stall got=%b exp=0", bus.o_wb_stall); end
        adv();
        idle();
    endtask

    task automatic test_reset_mid();
        for (int r = 12; r <= 14; r++) begin
            bus.i_ll_issue = 1'b1; bus.i_ll_issue_rd = 5'(r);
            adv();
        end
        bus.i_ll_issue = 1'b0;
        mid();
        checks++; if (bus.o_pending_cnt !== 6'd3) begin errors++; $display("FAIL rmid_pcnt_before got=%0d exp=3", bus.o_pending_cnt); end
        rst_n = 1'b0;
        bus.i_id_rs1 = 5'd12; bus.i_id_use_rs1 = 1'b1;
        bus.i_wb_valid = 1'b1; bus.i_wb_rd = 5'd2; bus.i_wb_data = 32'h2222_2222;
        bus.i_ll_valid = 1'b1; bus.i_ll_rd = 5'd13; bus.i_ll_data = 32'h1313_1313;
        #1;
        checks++; if (bus.o_pending_cnt !== 6'd0) begin errors++; $display("FAIL rmid_pcnt got=%0d exp=0", bus.o_pending_cnt); end
        checks++; if (bus.o_id_stall !== 1'b0) begin errors++; $display("FAIL rmid_id_stall got=%b exp=0", bus.o_id_stall); end
        checks++; if (bus.o_ll_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready got=%b exp=0", bus.o_ll_ready); end
        checks++; if (bus.o_wb_stall !== 1'b0) begin errors++; $display("FAIL rmid_wb_stall got=%b exp=0", bus.o_wb_stall); end
        checks++; if (bus.o_rd_wen !== 1'b0) begin errors++; $display("FAIL rmid_wen got=%b exp=0", bus.o_rd_wen); end
        adv();
        rst_n = 1'b1;
        bus.i_wb_valid = 1'b0; bus.i_ll_valid = 1'b0;
        mid();
        checks++; if (bus.o_pending_cnt !== 6'd0) begin errors++; $display("FAIL rmid_pcnt_after got=%0d exp=0", bus.o_pending_cnt); end
        checks++; if (bus.o_id_stall !== 1'b0) begin errors++; $display("FAIL rmid_no_stall_after got=%b exp=0", bus.o_id_stall); end
        adv();
        idle();
    endtask

    task automatic test_back_to_back();
        logic [4:0]  rd;
        logic [31:0] data;
        for (int i = 0; i < 10; i++) begin
            rd   = 5'($urandom_range(0, 31));
            data = $urandom;
            bus.i_wb_valid = 1'b1; bus.i_wb_rd = rd; bus.i_wb_data = data;
            if (rd != 5'd0) push_wr(rd, data);
            mid();
            checks++; if (bus.o_rd_wen !== (rd != 5'd0)) begin errors++; $display("FAIL b2b_wen_%0d got=%b exp=%b", i, bus.o_rd_wen, (rd != 5'd0)); end
            adv();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_wb_only();
        test_ll_starvation();
        test_raw();
        test_same_cycle();
        test_x0();
        test_reset_mid();
        test_back_to_back();
        mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL wr_queue_drained got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
